systolic_mm_ctrl: RTL and testbench

- Sequencer for the 3x3 systolic integer matrix-multiply array of 19 PEs and 6 delay cells.
- Accepts two 3x3 operand matrices with a start/busy handshake and drives the 3-cycle skewed operand feed into the array's five row lanes and five column lanes.
- Samples the five result taps of the array at fixed offsets and assembles the 9 products.
- Holds the result under a valid/ready handshake, then enforces a zero-feed flush before the next job is accepted.

---
 rtl/systolic_mm_ctrl.sv | 168 ++++++++++++++++
 tb/tb_systolic_mm_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mm_ctrl.sv
// Sequencer for the 3x3 systolic matrix-multiply array: skewed operand feed,
// result-tap capture, valid/ready result hold and zero-feed flush.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for start; operands latched on accept
// S_FEED     | k=0..2, skewed row/column vectors on the feed lanes
// S_DRAIN    | zero feed while the array settles, until k = CAP_OFS-1
// S_CAPTURE  | k=CAP_OFS..CAP_OFS+2, taps sampled into c_flat
// S_HOLD     | result held with res_valid until res_ready
// S_FLUSHING | zero feed for FLUSH cycles before the next job
module systolic_mm_ctrl #(
  parameter int N       = 5,
  parameter int CAP_OFS = 5,
  parameter int FLUSH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [9*N-1:0]        a_flat,
  input  logic [9*N-1:0]        b_flat,
  output logic                  busy,
  output logic                  start_drop,
  output logic [5*N-1:0]        a_feed,
  output logic [5*N-1:0]        b_feed,
  input  logic [2*N+3:0]        tap19,
  input  logic [2*N+3:0]        tap18,
  input  logic [2*N+3:0]        tap17,
  input  logic [2*N+3:0]        tap16,
  input  logic [2*N+3:0]        tap12,
  output logic [9*(2*N+4)-1:0]  c_flat,
  output logic                  res_valid,
  input  logic                  res_ready
);

  localparam int W  = 2*N + 4;
  localparam int KW = $clog2(CAP_OFS + 3) + 1;
  localparam int FW = $clog2(FLUSH + 1);

  localparam logic [KW-1:0] K_FEED_END  = KW'(2);
  localparam logic [KW-1:0] K_DRAIN_END = KW'(CAP_OFS - 1);
  localparam logic [KW-1:0] K_CAP0      = KW'(CAP_OFS);
  localparam logic [KW-1:0] K_CAP1      = KW'(CAP_OFS + 1);
  localparam logic [KW-1:0] K_CAP2      = KW'(CAP_OFS + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_FEED, S_DRAIN, S_CAPTURE, S_HOLD, S_FLUSHING
  } state_t;

  state_t            state, state_nxt;
  logic [KW-1:0]     k, k_nxt;
  logic [FW-1:0]     flush_cnt, flush_nxt;
  logic [9*N-1:0]    a_lat, a_lat_nxt, b_lat, b_lat_nxt;
  logic [5*N-1:0]    a_feed_nxt, b_feed_nxt;
  logic [9*W-1:0]    c_nxt;
  logic              res_valid_nxt, busy_nxt, start_drop_nxt;

  // Step j drives row j of A / column j of B onto lanes j..j+2.
  function automatic logic [5*N-1:0] feed_vec(input logic [9*N-1:0] m,
                                              input logic [1:0] j,
                                              input logic is_b);
    logic [5*N-1:0] v;
    v = '0;
    for (int i = 0; i < 3; i++) begin
      if (is_b) v[(int'(j) + i)*N +: N] = m[(int'(j) + 3*i)*N +: N];
      else      v[(int'(j) + i)*N +: N] = m[(3*int'(j) + i)*N +: N];
    end
    return v;
  endfunction

  always_comb begin
    state_nxt      = state;
    k_nxt          = k + KW'(1);
    flush_nxt      = flush_cnt;
    a_lat_nxt      = a_lat;
    b_lat_nxt      = b_lat;
    a_feed_nxt     = '0;
    b_feed_nxt     = '0;
    c_nxt          = c_flat;
    res_valid_nxt  = res_valid;
    start_drop_nxt = start && (state != S_IDLE);

    case (state)
      S_IDLE: begin
        k_nxt = '0;
        if (start) begin
          a_lat_nxt  = a_flat;
          b_lat_nxt  = b_flat;
          a_feed_nxt = feed_vec(a_flat, 2'd0, 1'b0);
          b_feed_nxt = feed_vec(b_flat, 2'd0, 1'b1);
          state_nxt  = S_FEED;
        end
      end
      S_FEED: begin
        if (k == K_FEED_END) begin
          state_nxt = (CAP_OFS == 3) ? S_CAPTURE : S_DRAIN;
        end else begin
          a_feed_nxt = feed_vec(a_lat, k[1:0] + 2'd1, 1'b0);
          b_feed_nxt = feed_vec(b_lat, k[1:0] + 2'd1, 1'b1);
        end
      end
      S_DRAIN: begin
        if (k == K_DRAIN_END) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        // Each tap carries a different C element on successive cycles.
        if (k == K_CAP0) begin
          c_nxt[0*W +: W] = tap19;
          c_nxt[1*W +: W] = tap16;
          c_nxt[2*W +: W] = tap12;
          c_nxt[3*W +: W] = tap18;
          c_nxt[6*W +: W] = tap17;
        end else if (k == K_CAP1) begin
          c_nxt[4*W +: W] = tap19;
          c_nxt[5*W +: W] = tap16;
          c_nxt[7*W +: W] = tap18;
        end else if (k == K_CAP2) begin
          c_nxt[8*W +: W] = tap19;
          res_valid_nxt   = 1'b1;
          state_nxt       = S_HOLD;
        end
      end
      S_HOLD: begin
        if (res_valid && res_ready) begin
          res_valid_nxt = 1'b0;
          flush_nxt     = FW'(FLUSH);
          state_nxt     = S_FLUSHING;
        end
      end
      S_FLUSHING: begin
        flush_nxt = flush_cnt - FW'(1);
        if (flush_cnt == FW'(1)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      k          <= '0;
      flush_cnt  <= '0;
      a_lat      <= '0;
      b_lat      <= '0;
      a_feed     <= '0;
      b_feed     <= '0;
      c_flat     <= '0;
      res_valid  <= 1'b0;
      busy       <= 1'b0;
      start_drop <= 1'b0;
    end else begin
      state      <= state_nxt;
      k          <= k_nxt;
      flush_cnt  <= flush_nxt;
      a_lat      <= a_lat_nxt;
      b_lat      <= b_lat_nxt;
      a_feed     <= a_feed_nxt;
      b_feed     <= b_feed_nxt;
      c_flat     <= c_nxt;
      res_valid  <= res_valid_nxt;
      busy       <= busy_nxt;
      start_drop <= start_drop_nxt;
    end
  end

endmodule

// File: tb/tb_systolic_mm_ctrl.sv
// Bench for systolic_mm_ctrl: scoreboarded results, per-cycle feed and drop
// expectations, and a tap model standing in for the systolic array.
module tb_systolic_mm_ctrl;

  localparam int N       = 5;
  localparam int CAP_OFS = 5;
  localparam int FLUSH   = 4;
  localparam int W       = 2*N + 4;
  localparam int DEPTH   = 4096;

  logic               clk, rst, start, res_ready;
  logic [9*N-1:0]     a_flat, b_flat;
  logic               busy, start_drop, res_valid;
  logic [5*N-1:0]     a_feed, b_feed;
  logic [W-1:0]       tap19, tap18, tap17, tap16, tap12;
  logic [9*W-1:0]     c_flat;

  systolic_mm_ctrl #(.N(N), .CAP_OFS(CAP_OFS), .FLUSH(FLUSH)) dut (
    .clk(clk), .rst(rst), .start(start), .a_flat(a_flat), .b_flat(b_flat),
    .busy(busy), .start_drop(start_drop), .a_feed(a_feed), .b_feed(b_feed),
    .tap19(tap19), .tap18(tap18), .tap17(tap17), .tap16(tap16), .tap12(tap12),
    .c_flat(c_flat), .res_valid(res_valid), .res_ready(res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [9*W-1:0] matmul(input logic [9*N-1:0] a, input logic [9*N-1:0] b);
    logic [9*W-1:0] c;
    int sum;
    c = '0;
    for (int r = 0; r < 3; r++)
      for (int col = 0; col < 3; col++) begin
        sum = 0;
        for (int t = 0; t < 3; t++)
          sum += int'(a[(3*r + t)*N +: N]) * int'(b[(3*t + col)*N +: N]);
        c[(3*r + col)*W +: W] = W'(sum);
      end
    return c;
  endfunction

  // Lane L at step j: A[j][L-j] and B[L-j][j] when 0 <= L-j < 3.
  function automatic logic [5*N-1:0] exp_feed(input logic [9*N-1:0] m, input int j, input bit is_b);
    logic [5*N-1:0] v;
    v = '0;
    for (int lane = 0; lane < 5; lane++) begin
      int d;
      d = lane - j;
      if (d >= 0 && d < 3)
        v[lane*N +: N] = is_b ? m[(3*d + j)*N +: N] : m[(3*j + d)*N +: N];
    end
    return v;
  endfunction

  function automatic logic [9*N-1:0] pack_seq(input int base, input int step);
    logic [9*N-1:0] m;
    for (int i = 0; i < 9; i++) m[i*N +: N] = N'(base + step*i);
    return m;
  endfunction

  function automatic logic [9*N-1:0] rand_mat();
    logic [9*N-1:0] m;
    for (int i = 0; i < 9; i++) m[i*N +: N] = N'($urandom_range(0, 31));
    return m;
  endfunction

  logic [5*N-1:0] exp_a [DEPTH];
  logic [5*N-1:0] exp_b [DEPTH];
  logic           exp_drop [DEPTH];

  typedef struct { logic [9*W-1:0] c; int e; } sb_t;
  sb_t sb_q[$];

  // ---------------- array tap model ----------------
  int             job_e   = -1000;
  int             tap_mode = 0;
  logic [9*W-1:0] tap_c;

  always @(negedge clk) begin
    int k;
    k = cyc - job_e;
    if (tap_mode == 0) begin
      tap19 = W'(16*k + 1);
      tap18 = W'(16*k + 2);
      tap17 = W'(16*k + 3);
      tap16 = W'(16*k + 4);
      tap12 = W'(16*k + 5);
    end else begin
      tap19 = W'($urandom); tap18 = W'($urandom); tap17 = W'($urandom);
      tap16 = W'($urandom); tap12 = W'($urandom);
      if (k == CAP_OFS) begin
        tap19 = tap_c[0*W +: W]; tap16 = tap_c[1*W +: W]; tap12 = tap_c[2*W +: W];
        tap18 = tap_c[3*W +: W]; tap17 = tap_c[6*W +: W];
      end else if (k == CAP_OFS + 1) begin
        tap19 = tap_c[4*W +: W]; tap16 = tap_c[5*W +: W]; tap18 = tap_c[7*W +: W];
      end else if (k == CAP_OFS + 2) begin
        tap19 = tap_c[8*W +: W];
      end
    end
  end

  // ---------------- monitor ----------------
  bit   mon_en = 0;
  logic prev_valid = 1'b0;
  sb_t  cur;

  always @(negedge clk) begin
    if (mon_en) begin
      check("a_feed", a_feed, exp_a[cyc]);
      check("b_feed", b_feed, exp_b[cyc]);
      check("start_drop", start_drop, exp_drop[cyc]);
      if (res_valid && !prev_valid) begin
        if (sb_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL res_valid_unexpected: got 1, expected 0 (cycle %0d)", cyc);
        end else begin
          cur = sb_q.pop_front();
          check("latency", cyc - cur.e, CAP_OFS + 3);
        end
      end
      if (res_valid) check("c_flat", c_flat, cur.c);
      prev_valid = res_valid;
    end
  end

  // ---------------- stimulus ----------------
  // Entered and left at a negedge in an IDLE cycle.
  task automatic run_job(input logic [9*N-1:0] a, input logic [9*N-1:0] b, input int mode,
                         input logic [9*W-1:0] c_exp, input int ready_delay,
                         input bit drop_test, input bit abort);
    int e, h;
    sb_t ent;
    e = cyc + 1;
    a_flat = a; b_flat = b; start = 1'b1;
    job_e = e; tap_mode = mode; tap_c = c_exp;
    for (int j = 0; j < 3; j++) begin
      exp_a[e + j] = exp_feed(a, j, 1'b0);
      exp_b[e + j] = exp_feed(b, j, 1'b1);
    end
    ent.c = c_exp; ent.e = e;
    sb_q.push_back(ent);
    @(negedge clk);
    start  = 1'b0;
    a_flat = (9*N)'({$urandom(), $urandom()});
    b_flat = (9*N)'({$urandom(), $urandom()});

    if (abort) begin
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_valid", res_valid, 0);
      check("abort_c_flat", c_flat, 0);
      check("abort_feed_a", a_feed, 0);
      void'(sb_q.pop_back());
      repeat (6) begin
        @(negedge clk);
        check("abort_no_valid", res_valid, 0);
      end
      job_e = -1000;
      return;
    end

    if (drop_test) begin
      repeat (2) @(negedge clk);
      start = 1'b1;
      exp_drop[cyc + 1] = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end

    while (cyc < e + CAP_OFS + 2) @(negedge clk);
    check("valid_early", res_valid, 0);
    @(negedge clk);
    check("valid_rise", res_valid, 1);
    repeat (ready_delay) begin
      @(negedge clk);
      check("valid_hold", res_valid, 1);
    end
    res_ready = 1'b1;
    h = cyc + 1;
    @(negedge clk);
    res_ready = 1'($urandom_range(0, 1));
    check("valid_fall", res_valid, 0);
    check("c_keep", c_flat, c_exp);
    while (cyc < h + FLUSH - 1) @(negedge clk);
    check("busy_flush_end", busy, 1);
    if (drop_test) begin
      start = 1'b1;
      exp_drop[cyc + 1] = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    res_ready = 1'b0;
    check("idle_after_flush", busy, 0);
  endtask

  initial begin
    logic [9*W-1:0] c_map;
    logic [9*N-1:0] a, b, ident;
    int mv[9] = '{81, 84, 85, 82, 97, 100, 83, 98, 113};

    for (int i = 0; i < DEPTH; i++) begin
      exp_a[i] = '0; exp_b[i] = '0; exp_drop[i] = 1'b0;
    end
    rst = 1'b1; start = 1'b0; res_ready = 1'b0; a_flat = '0; b_flat = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_start_drop", start_drop, 0);
    check("rst_valid", res_valid, 0);
    check("rst_c_flat", c_flat, 0);
    check("rst_a_feed", a_feed, 0);
    check("rst_b_feed", b_feed, 0);
    rst = 1'b0;
    mon_en = 1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) c_map[i*W +: W] = W'(mv[i]);
    run_job(pack_seq(1, 1), pack_seq(9, -1), 0, c_map, 0, 0, 0);

    a = pack_seq(31, 0);
    run_job(a, a, 1, matmul(a, a), 10, 0, 0);
    check("all31_c1", c_flat[0 +: W], 2883);

    ident = '0;
    ident[0*N +: N] = 1; ident[4*N +: N] = 1; ident[8*N +: N] = 1;
    a = pack_seq(1, 1);
    run_job(a, ident, 1, matmul(a, ident), 2, 1, 0);
    check("ident_c_eq_a", c_flat[8*W +: W], 9);

    a = rand_mat(); b = rand_mat();
    run_job(a, b, 1, matmul(a, b), 0, 0, 1);
    a = rand_mat(); b = rand_mat();
    run_job(a, b, 1, matmul(a, b), 1, 0, 0);

    for (int r = 0; r < 8; r++) begin
      a = rand_mat(); b = rand_mat();
      run_job(a, b, 1, matmul(a, b), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), 0);
    end

    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
